// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage data-memory access unit with req/ack bus, stall and write-back
module mem_access #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_reg2,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        stallreq,
    output logic        exc_misalign,
    output logic        exc_buserr
);
    localparam logic [2:0] OP_LW  = 3'd1;
    localparam logic [2:0] OP_LB  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_SW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic [31:0] load_data;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        abort;

    logic        is_mem, is_load, is_word, misaligned, timeout_hit;
    logic [3:0]  sel_c;
    logic [31:0] wdata_c;
    logic [7:0]  ld_byte;
    logic [31:0] load_val;

    always_comb begin
        is_mem      = (mem_op >= OP_LW) && (mem_op <= OP_SB);
        is_load     = (mem_op >= OP_LW) && (mem_op <= OP_LBU);
        is_word     = (mem_op == OP_LW) || (mem_op == OP_SW);
        misaligned  = is_word && (mem_wdata[1:0] != 2'b00);
        sel_c       = is_word ? 4'b1111 : (4'b1000 >> mem_wdata[1:0]);
        wdata_c     = (mem_op == OP_SB) ? {4{mem_reg2[7:0]}} : mem_reg2;
        timeout_hit = (cnt == CNT_LAST);
    end

    // Big-endian lane pick from the latched byte offset
    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = bus_rdata[31:24];
            2'd1:    ld_byte = bus_rdata[23:16];
            2'd2:    ld_byte = bus_rdata[15:8];
            default: ld_byte = bus_rdata[7:0];
        endcase
        case (op_q)
            OP_LW:   load_val = bus_rdata;
            OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
            default: load_val = {24'b0, ld_byte};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (is_mem && !misaligned) state_nxt = REQ;
            REQ:  if (bus_ack || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'b0;
            bus_sel      <= 4'b0;
            bus_wdata    <= 32'b0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
            cnt          <= 8'b0;
            load_data    <= 32'b0;
            op_q         <= 3'b0;
            lane_q       <= 2'b0;
            abort        <= 1'b0;
        end else begin
            state        <= state_nxt;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= 8'b0;
                    if (is_mem && misaligned) begin
                        exc_misalign <= 1'b1;
                    end else if (is_mem) begin
                        bus_req   <= 1'b1;
                        bus_we    <= !is_load;
                        bus_addr  <= {mem_wdata[31:2], 2'b00};
                        bus_sel   <= sel_c;
                        bus_wdata <= wdata_c;
                        op_q      <= mem_op;
                        lane_q    <= mem_wdata[1:0];
                        abort     <= 1'b0;
                    end
                end
                REQ: begin
                    // An ack in the timeout cycle takes priority over the abort
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        load_data <= load_val;
                    end else if (timeout_hit) begin
                        bus_req    <= 1'b0;
                        exc_buserr <= 1'b1;
                        abort      <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stallreq = ((state == IDLE) && is_mem && !misaligned) || (state == REQ);
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        case (state)
            IDLE: if (is_mem) wb_wreg = 1'b0;
            REQ:  wb_wreg = 1'b0;
            default: begin
                if ((op_q >= OP_LW) && (op_q <= OP_LBU)) begin
                    wb_wreg  = mem_wreg && !abort;
                    wb_wdata = load_data;
                end else begin
                    wb_wreg = 1'b0;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a behavioural model
module tb_mem_access;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  mem_wd = '0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [2:0]  mem_op = '0;
    logic [31:0] mem_reg2 = '0;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq, exc_misalign, exc_buserr;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_reg2(mem_reg2),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .stallreq(stallreq), .exc_misalign(exc_misalign), .exc_buserr(exc_buserr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit m_is_load(input logic [2:0] op);
        return op == 3'd1 || op == 3'd2 || op == 3'd3;
    endfunction

    function automatic bit m_is_word(input logic [2:0] op);
        return op == 3'd1 || op == 3'd4;
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [31:0] a);
        int off = int'(a % 4);
        if (m_is_word(op)) return 4'hF;
        return 4'(1 << (3 - off));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] r2);
        if (op == 3'd5) return (r2 & 32'hFF) * 32'h01010101;
        return r2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        int off = int'(a % 4);
        logic [31:0] b = (rd >> (8 * (3 - off))) & 32'hFF;
        if (op == 3'd1) return rd;
        if (op == 3'd2 && b >= 32'd128) return b | 32'hFFFFFF00;
        return b;
    endfunction

    // ack_at: REQ cycle (1-based) carrying bus_ack; 0 means never acknowledge
    task automatic run_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] r2,
                              input logic [4:0] wd, input bit wreg, input int ack_at,
                              input logic [31:0] rdata);
        int req_cycles = 0;
        bit ld = m_is_load(op);
        mem_op = op; mem_wdata = addr; mem_reg2 = r2; mem_wd = wd; mem_wreg = wreg; bus_ack = 1'b0;
        #1;
        chk("idle_stall", 32'(stallreq), 32'd1);
        chk("idle_wb_wreg", 32'(wb_wreg), 32'd0);
        step();
        chk("bus_req", 32'(bus_req), 32'd1);
        chk("bus_addr", bus_addr, addr & 32'hFFFFFFFC);
        chk("bus_sel", 32'(bus_sel), 32'(m_sel(op, addr)));
        chk("bus_we", 32'(bus_we), 32'(!ld));
        if (!ld) chk("bus_wdata", bus_wdata, m_wdata(op, r2));
        while (bus_req === 1'b1 && req_cycles < 3 * TIMEOUT) begin
            req_cycles++;
            if (stallreq !== 1'b1) chk("req_stall", 32'(stallreq), 32'd1);
            if (req_cycles == ack_at) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
            step();
            bus_ack = 1'b0;
            bus_rdata = $urandom;
        end
        chk("req_cycles", 32'(req_cycles), 32'(ack_at != 0 ? ack_at : TIMEOUT));
        chk("done_buserr", 32'(exc_buserr), 32'(ack_at == 0));
        chk("done_stall", 32'(stallreq), 32'd0);
        chk("done_wb_wreg", 32'(wb_wreg), 32'(ld && wreg && ack_at != 0));
        chk("done_wb_wd", 32'(wb_wd), 32'(wd));
        if (ld && ack_at != 0) chk("done_wb_wdata", wb_wdata, m_load(op, addr, rdata));
        step();
        mem_op = 3'd0;
        #1;
        chk("after_buserr", 32'(exc_buserr), 32'd0);
        chk("after_stall", 32'(stallreq), 32'd0);
        chk("after_bus_req", 32'(bus_req), 32'd0);
    endtask

    task automatic run_misaligned(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] r2);
        mem_op = op; mem_wdata = addr; mem_reg2 = r2; mem_wreg = 1'b1;
        #1;
        chk("mis_stall", 32'(stallreq), 32'd0);
        chk("mis_wb_wreg", 32'(wb_wreg), 32'd0);
        step();
        chk("mis_bus_req", 32'(bus_req), 32'd0);
        chk("mis_exc", 32'(exc_misalign), 32'd1);
        mem_op = 3'd0;
        step();
        chk("mis_exc_clear", 32'(exc_misalign), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_sel", 32'(bus_sel), 32'd0);
        chk("rst_exc", 32'({exc_misalign, exc_buserr}), 32'd0);
        rst = 1'b1;
        step();

        // ALU pass-through, with a stray ack that must be ignored
        mem_op = 3'd0; mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h1234; bus_ack = 1'b1;
        #1;
        chk("pt_wb_wd", 32'(wb_wd), 32'd5);
        chk("pt_wb_wreg", 32'(wb_wreg), 32'd1);
        chk("pt_wb_wdata", wb_wdata, 32'h1234);
        chk("pt_stall", 32'(stallreq), 32'd0);
        step();
        bus_ack = 1'b0;
        chk("pt_bus_req", 32'(bus_req), 32'd0);

        run_access(3'd1, 32'h100, 32'h0, 5'd7, 1'b1, 3, 32'hDEADBEEF);
        run_access(3'd2, 32'h103, 32'h0, 5'd8, 1'b1, 1, 32'h000000F0);
        run_access(3'd3, 32'h103, 32'h0, 5'd9, 1'b1, 2, 32'h000000F0);
        run_access(3'd5, 32'h101, 32'h000000AB, 5'd3, 1'b1, 1, 32'h0);
        run_misaligned(3'd4, 32'h102, 32'h12345678);
        run_access(3'd1, 32'h200, 32'h0, 5'd4, 1'b1, 0, 32'h0);
        run_access(3'd1, 32'h204, 32'h0, 5'd4, 1'b1, TIMEOUT, 32'hCAFEF00D);

        // Asynchronous reset while the bus request is outstanding
        mem_op = 3'd1; mem_wdata = 32'h300; mem_wreg = 1'b1;
        step();
        step();
        chk("mid_req", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b0;
        mem_op = 3'd0;
        #1;
        chk("arst_bus_req", 32'(bus_req), 32'd0);
        chk("arst_stall", 32'(stallreq), 32'd0);
        chk("arst_exc", 32'({exc_misalign, exc_buserr}), 32'd0);
        step();
        rst = 1'b1;
        step();
        run_access(3'd1, 32'h304, 32'h0, 5'd6, 1'b1, 2, 32'h87654321);

        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op = 3'($urandom_range(1, 5));
            logic [31:0] a = $urandom & 32'h0000FFFF;
            int          ack = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            if (m_is_word(op) && a[1:0] != 2'b00 && $urandom_range(0, 1) == 1)
                run_misaligned(op, a, $urandom);
            else begin
                if (m_is_word(op)) a = a & 32'hFFFFFFFC;
                run_access(op, a, $urandom, 5'($urandom), 1'($urandom), ack, $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage data-memory access unit. Consumes the EX/MEM pipeline register outputs (destination, write-enable, ALU result, memory op, store data) and drives a req/ack data bus for loads and stores.
- Requests a pipeline stall while a bus transaction is outstanding.
- Presents the final write-back triple to the MEM/WB register.
- Big-endian byte lanes, MIPS LW/LB/LBU/SW/SB.

Parameters:
- TIMEOUT, 16, cycles with bus_req high and no bus_ack before the access is aborted (range 2..255).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_wd  in  5  destination register address.
- mem_wreg  in  1  register write enable.
- mem_wdata  in  32  ALU result; also the memory byte address for load/store ops.
- mem_op  in  3  0 NONE, 1 LW, 2 LB, 3 LBU, 4 SW, 5 SB; 6 and 7 are treated as NONE.
- mem_reg2  in  32  store data (rt).
- bus_req  out  1  request, registered.
- bus_we  out  1  1 = write, registered.
- bus_addr  out  32  word address with {addr[31:2],2'b00}, registered.
- bus_sel  out  4  byte enables, bit3 = bits 31:24, registered.
- bus_wdata  out  32  write data, registered.
- bus_ack  in  1  one-cycle completion strobe.
- bus_rdata  in  32  read data, valid when bus_ack = 1.
- wb_wd  out  5  to MEM/WB.
- wb_wreg  out  1  to MEM/WB.
- wb_wdata  out  32  to MEM/WB.
- stallreq  out  1  combinational stall request to the pipeline control.
- exc_misalign  out  1  one-cycle pulse, registered.
- exc_buserr  out  1  one-cycle pulse, registered.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - bus_req, bus_we, exc_* = 0; bus_addr, bus_wdata = 0; bus_sel = 0.
  - Timeout counter = 0; load-data register = 0.
- is_mem = mem_op in 1..5. is_load = mem_op in 1..3.
- Misaligned = (LW or SW) and addr[1:0] != 0.
- Lane mapping for byte ops: addr[1:0] = 00 uses bits 31:24 (sel 1000); 01 uses 23:16 (0100); 10 uses 15:8 (0010); 11 uses 7:0 (0001).
- Word ops use sel 1111.
- SB replicates mem_reg2[7:0] into all four bytes of bus_wdata. SW drives mem_reg2.
- FSM states:
  - IDLE:
    - is_mem and misaligned: stay in IDLE, no bus cycle, exc_misalign = 1 next cycle, stallreq = 0.
    - is_mem and aligned: next cycle bus_req = 1 with bus_we/addr/sel/wdata latched from the inputs, state becomes REQ.
    - Otherwise: pass-through.
  - REQ: bus outputs held stable. The timeout counter increments every cycle bus_ack = 0.
    - bus_ack = 1: capture the load result, drop bus_req next cycle, go to DONE.
    - Counter reaches TIMEOUT - 1 with no ack: drop bus_req, exc_buserr = 1 for one cycle, go to DONE with the abort flag set.
  - DONE: one cycle, then IDLE. This state prevents restarting the same instruction, which is still held in EX/MEM during the cycle stall releases.
- Load result:
  - LW: the rdata word.
  - LB: the selected byte, sign-extended.
  - LBU: the selected byte, zero-extended.
- stallreq = (IDLE and is_mem and not misaligned) or REQ. stallreq = 0 in DONE.
- Write-back outputs (combinational):
  - wb_wd = mem_wd in all states.
  - IDLE, non-mem op: wb_wreg = mem_wreg, wb_wdata = mem_wdata.
  - IDLE, misaligned: wb_wreg = 0.
  - Any state with stallreq = 1: wb_wreg = 0.
  - DONE after a load: wb_wreg = mem_wreg and not abort; wb_wdata = captured load data.
  - DONE after a store: wb_wreg = 0.
  - Stores never write back.
- bus_ack outside REQ is ignored.
- bus_ack in the same cycle the timeout fires: the ack wins, no error.
- Reset mid-transaction aborts immediately: bus_req drops asynchronously and no pulse is raised.

Test Plan:
- ALU pass-through: mem_op = 0, mem_wd = 5, mem_wreg = 1, mem_wdata = 32'h1234 → wb_* mirror the inputs the same cycle, stallreq = 0, bus_req stays 0.
- LW at 0x100, ack after 3 cycles with rdata = 32'hDEADBEEF:
  - bus_req = 1 with addr 0x100, sel 1111, we = 0.
  - stallreq high through the ack cycle.
  - DONE: wb_wreg = 1, wb_wdata = 32'hDEADBEEF, then IDLE.
- Byte loads at addr 0x103, rdata = 32'h000000F0:
  - LB → sel 0001, wb_wdata = 32'hFFFFFFF0.
  - LBU → wb_wdata = 32'h000000F0.
- Stores:
  - SB at 0x101, reg2 = 32'h000000AB → sel 0100, wdata = 32'hABABABAB, we = 1, wb_wreg = 0.
  - SW at 0x102 → no bus_req, exc_misalign pulses once, stallreq = 0.
- Timeout: LW with no ack, TIMEOUT = 16:
  - bus_req high for exactly 16 cycles.
  - exc_buserr pulses once, DONE with wb_wreg = 0, stall releases.
  - Repeat with ack on the 16th cycle → no error, data written back.
- Reset mid-REQ: assert rst = 0 asynchronously between edges → bus_req and stallreq drop without a clock edge; after release, state = IDLE and a new LW starts normally.
